fifo2_drain: RTL and testbench

Consumer-side companion to the 4-entry 1-bit `fifo2` queue in MicroEV20. It drives the queue's `pop`, captures the registered bit on `P`, and assembles `WORD_W` bits into a parallel word. The word is presented on a valid/ready handshake. `fifo2` exposes no level flags, so this block tracks queue occupancy itself by snooping the producer's `push` and `clear`.

---
 rtl/ev_fifo_pkg.sv | 13 +
 rtl/fifo_level_tracker.sv | 49 ++++
 rtl/fifo2_drain.sv | 87 ++++++++
 tb/tb_fifo2_drain.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ev_fifo_pkg.sv
// Shared definitions for blocks that sit around the MicroEV20 fifo2 queue.
package ev_fifo_pkg;

  localparam int unsigned FIFO2_DEPTH = 4;

  typedef enum logic [0:0] {StFill, StFull} drain_state_e;

  // Bits needed to hold a count from 0 to depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_level_tracker.sv
// Shadow occupancy counter for fifo2, built from snooped push/pop/clear,
// with a sticky overflow flag for pushes into a full queue.
module fifo_level_tracker
  import ev_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO2_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        overflow
);

  localparam int unsigned LW = level_w(DEPTH);
  localparam logic [LW-1:0] LevelMax = LW'(DEPTH);

  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clear) begin
      level_d = '0;
    end else if (push && !pop && level_q == LevelMax) begin
      // fifo2 drops the bit; keep the count saturated.
      overflow_d = 1'b1;
    end else begin
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/fifo2_drain.sv
// Pops fifo2 one bit at a time and assembles WORD_W bits (first bit in bit 0)
// into a word offered on a valid/ready handshake.
module fifo2_drain
  import ev_fifo_pkg::*;
#(
  parameter int unsigned WORD_W = 4,
  parameter int unsigned DEPTH  = FIFO2_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_push,
  input  logic                        fifo_clear,
  output logic                        fifo_pop,
  input  logic                        fifo_p,
  output logic [WORD_W-1:0]           word_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overflow,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int unsigned CW = level_w(WORD_W);
  localparam logic [CW-1:0] IssueMax = CW'(WORD_W);
  localparam logic [CW-1:0] GotLast  = CW'(WORD_W - 1);

  drain_state_e      state_q;
  logic [CW-1:0]     issued_q;
  logic [CW-1:0]     got_q;
  logic              cap_pending_q;
  logic [WORD_W-1:0] word_data_q;
  logic [WORD_W-1:0] shift_next;

  fifo_level_tracker #(
    .DEPTH(DEPTH)
  ) u_level (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .level   (level),
    .overflow(overflow)
  );

  // Pop decode uses registered state only, so fifo_pop has no input-to-output path.
  assign fifo_pop   = (level != '0) && (state_q == StFill) && (issued_q < IssueMax);
  assign shift_next = WORD_W'({fifo_p, word_data_q} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFill;
      issued_q      <= '0;
      got_q         <= '0;
      cap_pending_q <= 1'b0;
      word_data_q   <= '0;
    end else begin
      // A pop in the clear cycle still moves fifo2.P, but that bit is dropped.
      cap_pending_q <= fifo_pop && !fifo_clear;
      unique case (state_q)
        StFill: begin
          if (fifo_clear) begin
            issued_q <= '0;
            got_q    <= '0;
          end else begin
            if (fifo_pop) issued_q <= issued_q + CW'(1);
            if (cap_pending_q) begin
              word_data_q <= shift_next;
              got_q       <= got_q + CW'(1);
              if (got_q == GotLast) state_q <= StFull;
            end
          end
        end
        StFull: begin
          if (word_ready) begin
            state_q  <= StFill;
            issued_q <= '0;
            got_q    <= '0;
          end
        end
      endcase
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = (state_q == StFull);

endmodule

// File: tb/tb_fifo2_drain.sv
// Directed bench: fifo2_drain fed by a behavioural 4-entry fifo2 queue.
module tb_fifo2_drain;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_push = 1'b0;
  logic       push_bit = 1'b0;
  logic       fifo_clear = 1'b0;
  logic       fifo_pop;
  logic       fifo_p;
  logic [3:0] word_data;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       overflow;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo2_drain #(
    .WORD_W(4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_push (fifo_push),
    .fifo_clear(fifo_clear),
    .fifo_pop  (fifo_pop),
    .fifo_p    (fifo_p),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .overflow  (overflow),
    .level     (level)
  );

  // fifo2: pop registers the head onto P; clear empties; pushes into a full queue are lost.
  logic q[$];
  logic p_q;
  assign fifo_p = p_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      p_q <= 1'b0;
    end else begin
      if (fifo_pop && q.size() != 0) p_q <= q[0];
      if (fifo_clear) begin
        q.delete();
      end else begin
        if (fifo_pop && q.size() != 0) void'(q.pop_front());
        if (fifo_push && q.size() < 4) q.push_back(push_bit);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_push = 1'b1;
      push_bit  = b[i];
      tick();
    end
    fifo_push = 1'b0;
    push_bit  = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!word_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, word_valid}, 32'd1);
  endtask

  initial begin
    logic [7:0] bv;
    logic [6:0] exp_pop;
    logic [6:0] exp_valid;
    int         nwords;
    logic [3:0] exp_words [2];

    // Reset state
    tick();
    tick();
    chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_data", {28'd0, word_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic word: push 1,0,1,1 in cycles 0-3; pops in 1-4, valid in cycle 6
    word_ready = 1'b1;
    bv        = 8'b0000_1101;
    exp_pop   = 7'b0011110;
    exp_valid = 7'b1000000;
    for (int c = 0; c < 7; c++) begin
      fifo_push = (c < 4);
      push_bit  = bv[c];
      chk($sformatf("basic_pop_c%0d", c), {31'd0, fifo_pop}, {31'd0, exp_pop[c]});
      chk($sformatf("basic_valid_c%0d", c), {31'd0, word_valid}, {31'd0, exp_valid[c]});
      if (c == 6) chk("basic_data", {28'd0, word_data}, 32'h0000_000d);
      tick();
    end
    fifo_push = 1'b0;
    chk("basic_accepted", {31'd0, word_valid}, 32'd0);
    chk("basic_level", {29'd0, level}, 32'd0);

    // Reset mid-word after two captures, then a fresh word from bit 0
    fifo_push = 1'b1;
    push_bit  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    fifo_push = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_pop", {31'd0, fifo_pop}, 32'd0);
    chk("midrst_valid", {31'd0, word_valid}, 32'd0);
    chk("midrst_data", {28'd0, word_data}, 32'd0);
    chk("midrst_level", {29'd0, level}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_bits(8'b0000_0010, 4);
    wait_valid(10);
    chk("midrst_word", {28'd0, word_data}, 32'h0000_0002);
    tick();

    // Backpressure: 8 bits with ready low
    word_ready = 1'b0;
    push_bits(8'b1010_0011, 8);
    chk("bp_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_word0", {28'd0, word_data}, 32'h0000_0003);
    chk("bp_level_full", {29'd0, level}, 32'd4);
    chk("bp_no_pop", {31'd0, fifo_pop}, 32'd0);
    tick();
    tick();
    chk("bp_word0_stable", {28'd0, word_data}, 32'h0000_0003);
    word_ready = 1'b1;
    tick();
    chk("bp_pop_after_accept", {31'd0, fifo_pop}, 32'd1);
    wait_valid(12);
    chk("bp_word1", {28'd0, word_data}, 32'h0000_000a);
    tick();
    chk("bp_drained_valid", {31'd0, word_valid}, 32'd0);
    chk("bp_drained_level", {29'd0, level}, 32'd0);

    // Clear mid-word during the second pop
    fifo_push = 1'b1;
    push_bit  = 1'b1;
    tick();
    chk("clr_pop1", {31'd0, fifo_pop}, 32'd1);
    tick();
    fifo_push = 1'b0;
    chk("clr_pop2", {31'd0, fifo_pop}, 32'd1);
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    chk("clr_level", {29'd0, level}, 32'd0);
    chk("clr_no_pop", {31'd0, fifo_pop}, 32'd0);
    push_bits(8'b0000_0110, 4);
    wait_valid(10);
    chk("clr_word", {28'd0, word_data}, 32'h0000_0006);
    tick();

    // Overflow while a word is held, then clear in FULL keeps the word
    word_ready = 1'b0;
    push_bits(8'b0000_0101, 4);
    wait_valid(10);
    chk("ovf_word", {28'd0, word_data}, 32'h0000_0005);
    fifo_push = 1'b1;
    push_bit  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_level4", {29'd0, level}, 32'd4);
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    tick();
    fifo_push = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_level_sat", {29'd0, level}, 32'd4);
    tick();
    tick();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    chk("fullclr_level", {29'd0, level}, 32'd0);
    chk("fullclr_valid", {31'd0, word_valid}, 32'd1);
    chk("fullclr_data", {28'd0, word_data}, 32'h0000_0005);
    chk("fullclr_ovf", {31'd0, overflow}, 32'd1);
    word_ready = 1'b1;
    tick();
    chk("fullclr_accept", {31'd0, word_valid}, 32'd0);
    chk("fullclr_no_pop", {31'd0, fifo_pop}, 32'd0);

    // Continuous push with simultaneous pops
    bv = 8'b1011_1001;
    exp_words[0] = 4'b1001;
    exp_words[1] = 4'b1011;
    nwords = 0;
    for (int c = 0; c < 16; c++) begin
      fifo_push = (c < 8);
      push_bit  = (c < 8) ? bv[c] : 1'b0;
      if (c >= 1 && c <= 5) chk($sformatf("pp_level_c%0d", c), {29'd0, level}, 32'd1);
      if (word_valid) begin
        if (nwords < 2)
          chk($sformatf("pp_word%0d", nwords), {28'd0, word_data}, {28'd0, exp_words[nwords]});
        nwords++;
      end
      tick();
    end
    fifo_push = 1'b0;
    chk("pp_word_count", nwords, 32'd2);
    chk("pp_level_end", {29'd0, level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
